// File: rtl/cache_tag_array.sv
// Tag/valid/dirty store with a registered read port, one write port and a flush engine.
// Optional same-cycle write-to-read forwarding under `TAG_ARRAY_BYPASS_EN.
module cache_tag_array #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rdirty,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wdirty,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic                  fl_valid,
  input  logic                  fl_ready,
  output logic [ADDR_WIDTH-1:0] fl_addr,
  output logic [DATA_WIDTH-1:0] fl_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      dirty_q, dirty_d;
  logic [DATA_WIDTH-1:0] tag_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rdirty_q, rdirty_d;
  logic                  wr_acc;

  // Writes are locked out for the whole flush so the walk never races the controller.
  assign wr_acc = wen && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_acc) begin
      valid_d[waddr] = 1'b1;
      dirty_d[waddr] = wdirty;
    end
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (valid_q[idx_q] && dirty_q[idx_q]) begin
          state_d = EMIT;
        end else begin
          valid_d[idx_q] = 1'b0;
          if (idx_q == LAST) state_d = DONE;
          else               idx_d   = idx_q + 1'b1;
        end
      end
      EMIT: begin
        if (fl_ready) begin
          valid_d[idx_q] = 1'b0;
          dirty_d[idx_q] = 1'b0;
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    rdirty_d = rdirty_q;
    if (rd_en) begin
`ifdef TAG_ARRAY_BYPASS_EN
      if (wr_acc && (waddr == raddr)) begin
        rdata_d  = wdata;
        rvalid_d = 1'b1;
        rdirty_d = wdirty;
      end else begin
        rdata_d  = tag_q[raddr];
        rvalid_d = valid_q[raddr];
        rdirty_d = valid_q[raddr] & dirty_q[raddr];
      end
`else
      rdata_d  = tag_q[raddr];
      rvalid_d = valid_q[raddr];
      rdirty_d = valid_q[raddr] & dirty_q[raddr];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdirty_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rdirty_q <= rdirty_d;
    end
  end

  // Tag storage carries no reset; validity lives in valid_q.
  always_ff @(posedge clk) begin
    if (wr_acc) tag_q[waddr] <= wdata;
  end

  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign rdirty     = rdirty_q;
  assign flush_busy = (state_q != IDLE);
  assign flush_done = (state_q == DONE);
  assign fl_valid   = (state_q == EMIT);
  assign fl_addr    = idx_q;
  assign fl_data    = tag_q[idx_q];

endmodule

// File: tb/tb_cache_tag_array.sv
// Directed bench for cache_tag_array: table of read/write vectors plus flush and reset sequences.
module tb_cache_tag_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic [2:0]  raddr = '0;
  logic [23:0] rdata;
  logic        rvalid, rdirty;
  logic        wen = 1'b0;
  logic [2:0]  waddr = '0;
  logic [23:0] wdata = '0;
  logic        wdirty = 1'b0;
  logic        flush_req = 1'b0;
  logic        flush_busy, flush_done, fl_valid;
  logic        fl_ready = 1'b0;
  logic [2:0]  fl_addr;
  logic [23:0] fl_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_tag_array #(.ADDR_WIDTH(3), .DATA_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .raddr(raddr), .rdata(rdata),
    .rvalid(rvalid), .rdirty(rdirty), .wen(wen), .waddr(waddr), .wdata(wdata),
    .wdirty(wdirty), .flush_req(flush_req), .flush_busy(flush_busy),
    .flush_done(flush_done), .fl_valid(fl_valid), .fl_ready(fl_ready),
    .fl_addr(fl_addr), .fl_data(fl_data)
  );

  typedef struct {
    logic        wen;
    logic [2:0]  waddr;
    logic [23:0] wdata;
    logic        wdirty;
    logic        rd_en;
    logic [2:0]  raddr;
    logic [23:0] e_data;
    logic        e_valid;
    logic        e_dirty;
    logic        chk_data;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_tag(input logic [2:0] a, input logic [23:0] d, input logic dy);
    wen = 1'b1; waddr = a; wdata = d; wdirty = dy;
    tick();
    wen = 1'b0;
  endtask

  task automatic do_rst();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
  endtask

  initial begin
    int n1, n6, done_cnt, seq_n, done_k, fl_seen;
    logic [2:0]  seq [4];
    logic [23:0] got_data;

    // Read/write table; rows 4 and 6 are same-index read+write.
    vt[0] = '{1'b0, 3'd0, 24'h0,      1'b0, 1'b1, 3'd5, 24'h0,      1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 3'd5, 24'hABCDEF, 1'b1, 1'b0, 3'd0, 24'h0,      1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 3'd0, 24'h0,      1'b0, 1'b1, 3'd5, 24'hABCDEF, 1'b1, 1'b1, 1'b1};
    vt[3] = '{1'b1, 3'd2, 24'h000011, 1'b0, 1'b0, 3'd0, 24'hABCDEF, 1'b1, 1'b1, 1'b1};
`ifdef TAG_ARRAY_BYPASS_EN
    vt[4] = '{1'b1, 3'd2, 24'h000022, 1'b1, 1'b1, 3'd2, 24'h000022, 1'b1, 1'b1, 1'b1};
    vt[6] = '{1'b1, 3'd5, 24'h123456, 1'b0, 1'b1, 3'd5, 24'h123456, 1'b1, 1'b0, 1'b1};
`else
    vt[4] = '{1'b1, 3'd2, 24'h000022, 1'b1, 1'b1, 3'd2, 24'h000011, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b1, 3'd5, 24'h123456, 1'b0, 1'b1, 3'd5, 24'hABCDEF, 1'b1, 1'b1, 1'b1};
`endif
    vt[5] = '{1'b0, 3'd0, 24'h0,      1'b0, 1'b1, 3'd2, 24'h000022, 1'b1, 1'b1, 1'b1};
    vt[7] = '{1'b0, 3'd0, 24'h0,      1'b0, 1'b1, 3'd5, 24'h123456, 1'b1, 1'b0, 1'b1};
    vt[8] = '{1'b1, 3'd7, 24'hFFFFFF, 1'b1, 1'b1, 3'd0, 24'h0,      1'b0, 1'b0, 1'b0};
    vt[9] = '{1'b0, 3'd0, 24'h0,      1'b0, 1'b1, 3'd7, 24'hFFFFFF, 1'b1, 1'b1, 1'b1};

    #12 rst = 1'b0;
    tick();
    chk("rst_busy", flush_busy, 0);
    chk("rst_done", flush_done, 0);
    chk("rst_flvalid", fl_valid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);

    // Async reset mid-cycle while a flush is running
    wr_tag(3'd3, 24'h333333, 1'b1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("flush_started", flush_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", flush_busy, 0);
    #2 rst = 1'b0;
    tick();
    rd_en = 1'b1; raddr = 3'd3;
    tick();
    rd_en = 1'b0;
    chk("rst_clears_valid", rvalid, 0);
    chk("rst_clears_dirty", rdirty, 0);

    for (int unsigned i = 0; i < 10; i++) begin
      wen = vt[i].wen; waddr = vt[i].waddr; wdata = vt[i].wdata; wdirty = vt[i].wdirty;
      rd_en = vt[i].rd_en; raddr = vt[i].raddr;
      tick();
      wen = 1'b0; rd_en = 1'b0;
      chk($sformatf("vec%0d_rvalid", i), rvalid, vt[i].e_valid);
      chk($sformatf("vec%0d_rdirty", i), rdirty, vt[i].e_dirty);
      if (vt[i].chk_data) chk($sformatf("vec%0d_rdata", i), rdata, vt[i].e_data);
    end

    // Flush with back-pressure on idx 1
    do_rst();
    wr_tag(3'd1, 24'h111111, 1'b1);
    wr_tag(3'd6, 24'h666666, 1'b1);
    wr_tag(3'd3, 24'h333333, 1'b0);
    fl_ready = 1'b0; n1 = 0; n6 = 0; done_cnt = 0; seq_n = 0;
    flush_req = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      flush_req = 1'b0;
      if (flush_done) done_cnt++;
      if (fl_valid) begin
        if (seq_n < 4 && (seq_n == 0 || seq[seq_n-1] != fl_addr)) begin
          seq[seq_n] = fl_addr;
          seq_n++;
        end
        if (fl_addr == 3'd1) begin
          n1++;
          chk("fl_data_idx1", fl_data, 24'h111111);
        end else if (fl_addr == 3'd6) begin
          n6++;
          chk("fl_data_idx6", fl_data, 24'h666666);
        end else begin
          chk("fl_addr_unexpected", fl_addr, 3'd1);
        end
        fl_ready = (fl_addr == 3'd1) ? (n1 == 4) : 1'b1;
      end else begin
        fl_ready = 1'b0;
      end
      if (done_cnt > 0 && !flush_busy) break;
    end
    fl_ready = 1'b0;
    chk("flush_emit_count", seq_n, 2);
    chk("flush_first_addr", seq[0], 3'd1);
    chk("flush_second_addr", seq[1], 3'd6);
    chk("idx1_hold_cycles", n1, 4);
    chk("idx6_hold_cycles", n6, 1);
    chk("flush_done_pulses", done_cnt, 1);
    chk("flush_idle_after", flush_busy, 0);
    for (int unsigned i = 0; i < 8; i++) begin
      rd_en = 1'b1; raddr = 3'(i);
      tick();
      chk($sformatf("post_flush_rvalid%0d", i), rvalid, 0);
    end
    rd_en = 1'b0;

    // Empty array flush latency
    do_rst();
    done_k = 0; done_cnt = 0; fl_seen = 0;
    flush_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      flush_req = 1'b0;
      if (fl_valid) fl_seen = 1;
      if (flush_done) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
      end
    end
    chk("empty_done_latency", done_k, 9);
    chk("empty_done_pulses", done_cnt, 1);
    chk("empty_no_flvalid", fl_seen, 0);
    chk("empty_idle_after", flush_busy, 0);

    // Reset during EMIT, then a clean re-run
    do_rst();
    wr_tag(3'd4, 24'h444444, 1'b1);
    fl_ready = 1'b0;
    flush_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      flush_req = 1'b0;
      if (fl_valid) break;
    end
    chk("emit_reached", fl_valid, 1);
    chk("emit_addr", fl_addr, 3'd4);
    #2 rst = 1'b1;
    #1;
    chk("rst_emit_flvalid", fl_valid, 0);
    chk("rst_emit_busy", flush_busy, 0);
    #2 rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (flush_done) done_cnt++;
    end
    chk("rst_emit_no_done", done_cnt, 0);

    wr_tag(3'd0, 24'hAAAAAA, 1'b1);
    fl_ready = 1'b1; done_cnt = 0; seq_n = 0; got_data = '0;
    flush_req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      flush_req = 1'b0;
      if (fl_valid) begin
        seq_n++;
        seq[0] = fl_addr;
        got_data = fl_data;
      end
      if (flush_done) done_cnt++;
      wen = flush_busy; waddr = 3'd5; wdata = 24'h555555; wdirty = 1'b1;
      if (done_cnt > 0 && !flush_busy) break;
    end
    wen = 1'b0; fl_ready = 1'b0;
    chk("reflush_emits", seq_n, 1);
    chk("reflush_addr", seq[0], 3'd0);
    chk("reflush_data", got_data, 24'hAAAAAA);
    chk("reflush_done", done_cnt, 1);
    rd_en = 1'b1; raddr = 3'd5;
    tick();
    rd_en = 1'b0;
    chk("wen_ignored_in_flush", rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
